// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo delay-line controller: state encoding,
// sample/gain widths and the saturating adder used by the wet/dry mixer.
package echo_pkg;

   localparam int SAMPLE_W = 16;
   localparam int GAIN_W   = 8;

   typedef enum logic [2:0] {
      st_clear = 3'd0,
      st_idle  = 3'd1,
      st_read  = 3'd2,
      st_capt  = 3'd3,
      st_write = 3'd4
   } state_t;

   // Two's-complement add with clamp to the representable sample range.
   function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b);
      logic [SAMPLE_W:0] sum;
      sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
      if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
         return sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
      return sum[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/echo_mix.sv
// Combinational mixer: sat(dry + floor(wet * gain / 2^GAIN_W)), signed samples, unsigned gain.
module echo_mix
   import echo_pkg::*;
(
   input  logic [SAMPLE_W-1:0] dry,
   input  logic [SAMPLE_W-1:0] wet,
   input  logic [GAIN_W-1:0]   gain,
   output logic [SAMPLE_W-1:0] mix
);

   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

   logic signed [PROD_W-1:0] wet_x;
   logic signed [PROD_W-1:0] gain_x;
   logic signed [PROD_W-1:0] prod;
   logic [SAMPLE_W-1:0]      scaled;

   assign wet_x  = {{(GAIN_W + 1){wet[SAMPLE_W-1]}}, wet};
   assign gain_x = {{(SAMPLE_W + 1){1'b0}}, gain};
   assign prod   = wet_x * gain_x;
   // Gain is strictly below 1.0, so the scaled wet always fits a sample word.
   assign scaled = SAMPLE_W'(prod >>> GAIN_W);
   assign mix    = sat_add(dry, scaled);

endmodule

// File: rtl/echo_delay_ctrl.sv
// Circular delay-line sequencer for the 4-bank SPRAM echo buffer; zero-fills the buffer after reset.
// Build option ECHO_FEEDBACK_EN: write back the saturated mix instead of the dry sample.
//
// state    | meaning
// ---------+----------------------------------------------------------
// st_clear | zero-fill one address per cycle after reset
// st_idle  | wait for sample strobe; latch sample/gain, issue read addr
// st_read  | memory fetching delayed sample
// st_capt  | read data valid; compute mix, issue write
// st_write | write in progress; advance pointer, emit output strobe
module echo_delay_ctrl
   import echo_pkg::*;
#(
   parameter int BITSIZE = SAMPLE_W,
   parameter int ADDRLEN = 16
)(
   input  logic               clk,
   input  logic               resetn,
   input  logic [BITSIZE-1:0] sample_in,
   input  logic               sample_in_valid,
   input  logic [ADDRLEN-1:0] delay,
   input  logic [GAIN_W-1:0]  gain,
   output logic [BITSIZE-1:0] sample_out,
   output logic               sample_out_valid,
   output logic               busy,
   output logic               overrun,
   output logic [ADDRLEN-1:0] mem_addr,
   output logic [BITSIZE-1:0] mem_datain,
   output logic               mem_wren,
   input  logic [BITSIZE-1:0] mem_dataout
);

   state_t             state, state_d;
   logic [ADDRLEN-1:0] clr_cnt, clr_cnt_d;
   logic [ADDRLEN-1:0] wr_ptr, wr_ptr_d;
   logic [BITSIZE-1:0] din_r, din_d;
   logic [GAIN_W-1:0]  gain_r, gain_d;
   logic [BITSIZE-1:0] mix_r, mix_d;
   logic [BITSIZE-1:0] mix_w;

   logic [BITSIZE-1:0] sample_out_d;
   logic               sample_out_valid_d;
   logic               busy_d;
   logic               overrun_d;
   logic [ADDRLEN-1:0] mem_addr_d;
   logic [BITSIZE-1:0] mem_datain_d;
   logic               mem_wren_d;

   echo_mix u_mix (
      .dry  (din_r),
      .wet  (mem_dataout),
      .gain (gain_r),
      .mix  (mix_w)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= st_clear;
         clr_cnt          <= '0;
         wr_ptr           <= '0;
         din_r            <= '0;
         gain_r           <= '0;
         mix_r            <= '0;
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
         busy             <= 1'b0;
         overrun          <= 1'b0;
         mem_addr         <= '0;
         mem_datain       <= '0;
         mem_wren         <= 1'b0;
      end else begin
         state            <= state_d;
         clr_cnt          <= clr_cnt_d;
         wr_ptr           <= wr_ptr_d;
         din_r            <= din_d;
         gain_r           <= gain_d;
         mix_r            <= mix_d;
         sample_out       <= sample_out_d;
         sample_out_valid <= sample_out_valid_d;
         busy             <= busy_d;
         overrun          <= overrun_d;
         mem_addr         <= mem_addr_d;
         mem_datain       <= mem_datain_d;
         mem_wren         <= mem_wren_d;
      end
   end

   // Outputs are registered from the decision made in the current state, so
   // each memory command appears on the bus during the cycle that follows.
   always_comb begin
      state_d            = state;
      clr_cnt_d          = clr_cnt;
      wr_ptr_d           = wr_ptr;
      din_d              = din_r;
      gain_d             = gain_r;
      mix_d              = mix_r;
      sample_out_d       = sample_out;
      sample_out_valid_d = 1'b0;
      busy_d             = 1'b1;
      overrun_d          = 1'b0;
      mem_addr_d         = mem_addr;
      mem_datain_d       = mem_datain;
      mem_wren_d         = 1'b0;

      unique case (state)
         st_clear: begin
            overrun_d    = sample_in_valid;
            mem_addr_d   = clr_cnt;
            mem_datain_d = '0;
            mem_wren_d   = 1'b1;
            clr_cnt_d    = clr_cnt + ADDRLEN'(1);
            if (clr_cnt == '1) begin
               state_d = st_idle;
            end
         end
         st_idle: begin
            busy_d = 1'b0;
            if (sample_in_valid) begin
               din_d      = sample_in;
               gain_d     = gain;
               mem_addr_d = wr_ptr - delay;
               busy_d     = 1'b1;
               state_d    = st_read;
            end
         end
         st_read: begin
            overrun_d = sample_in_valid;
            state_d   = st_capt;
         end
         st_capt: begin
            overrun_d  = sample_in_valid;
            mix_d      = mix_w;
            mem_addr_d = wr_ptr;
            mem_wren_d = 1'b1;
`ifdef ECHO_FEEDBACK_EN
            mem_datain_d = mix_w;
`else
            mem_datain_d = din_r;
`endif
            state_d = st_write;
         end
         st_write: begin
            overrun_d          = sample_in_valid;
            wr_ptr_d           = wr_ptr + ADDRLEN'(1);
            sample_out_d       = mix_r;
            sample_out_valid_d = 1'b1;
            busy_d             = 1'b0;
            state_d            = st_idle;
         end
         default: begin
            state_d = st_clear;
         end
      endcase
   end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Self-checking bench for echo_delay_ctrl with a 16-entry buffer and a behavioural SPRAM.
module tb_echo_delay_ctrl;

   localparam int AL    = 4;
   localparam int DEPTH = 1 << AL;
`ifdef ECHO_FEEDBACK_EN
   localparam bit FB = 1'b1;
`else
   localparam bit FB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [15:0]   sample_in = '0;
   logic          sample_in_valid = 1'b0;
   logic [AL-1:0] delay = '0;
   logic [7:0]    gain = '0;
   logic [15:0]   sample_out;
   logic          sample_out_valid;
   logic          busy;
   logic          overrun;
   logic [AL-1:0] mem_addr;
   logic [15:0]   mem_datain;
   logic          mem_wren;
   logic [15:0]   mem_dataout = '0;

   logic [15:0]   spram [DEPTH];

   int checks = 0;
   int errors = 0;
   int hist [DEPTH];
   int wr_idx = 0;

   always #5 clk = ~clk;

   echo_delay_ctrl #(.BITSIZE(16), .ADDRLEN(AL)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .delay            (delay),
      .gain             (gain),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .busy             (busy),
      .overrun          (overrun),
      .mem_addr         (mem_addr),
      .mem_datain       (mem_datain),
      .mem_wren         (mem_wren),
      .mem_dataout      (mem_dataout)
   );

   // Synchronous single-port RAM, read-before-write, one cycle latency.
   initial begin
      for (int i = 0; i < DEPTH; i++) spram[i] = 16'hBEEF;
   end
   always @(posedge clk) begin
      if (mem_wren) spram[mem_addr] <= mem_datain;
      mem_dataout <= spram[mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   function automatic int ref_mix(int dry, int wet, int g);
      int s;
      s = dry + int'($floor(real'(wet * g) / 256.0));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // Reset, then watch the zero-fill; optionally strobe a sample during it.
   task automatic reset_clear(input int strobe_cycle);
      resetn = 1'b0;
      sample_in_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_out", $signed(sample_out), 0);
      check("rst_ctl", {sample_out_valid, busy, overrun, mem_wren}, 0);
      check("rst_mem", {mem_addr, mem_datain}, 0);
      resetn = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(posedge clk); #1;
         if (strobe_cycle != 0 && k == strobe_cycle) check("clr_overrun", overrun, 1);
         sample_in_valid = (k + 1 == strobe_cycle);
         check("clr_addr", mem_addr, k);
         check("clr_wr", {busy, mem_wren, mem_datain}, {1'b1, 1'b1, 16'h0});
      end
      @(posedge clk); #1;
      check("clr_end", {busy, mem_wren}, 0);
      for (int i = 0; i < DEPTH; i++) hist[i] = 0;
      wr_idx = 0;
   endtask

   // One sample through the line; ovr adds a dropped strobe two cycles in.
   task automatic do_sample(input int x, input int d, input int g, input bit ovr);
      int rd, y, wv;
      rd = (wr_idx - d + DEPTH) % DEPTH;
      y  = ref_mix(x, hist[rd], g);
      wv = FB ? y : x;
      sample_in = 16'(x);
      delay = AL'(d);
      gain = 8'(g);
      sample_in_valid = 1'b1;
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      check("rd_addr", mem_addr, rd);
      check("rd_ctl", {mem_wren, busy}, 2'b01);
      @(posedge clk); #1;
      check("capt_wren", mem_wren, 0);
      if (ovr) begin
         sample_in = 16'(x ^ 16'h5a5a);
         sample_in_valid = 1'b1;
      end
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      if (ovr) check("ovr_pulse", overrun, 1);
      check("wr_addr", mem_addr, wr_idx);
      check("wr_en", mem_wren, 1);
      check("wr_data", $signed(mem_datain), wv);
      @(posedge clk); #1;
      check("out_valid", sample_out_valid, 1);
      check("out_data", $signed(sample_out), y);
      check("out_busy", busy, 0);
      hist[wr_idx] = wv;
      wr_idx = (wr_idx + 1) % DEPTH;
      if (ovr) begin
         check("ovr_clear", overrun, 0);
         @(posedge clk); #1;
         check("hold_valid", sample_out_valid, 0);
         check("hold_data", $signed(sample_out), y);
      end
   endtask

   initial begin
      reset_clear(5);

      do_sample(100, 3, 255, 1'b0);
      do_sample(200, 3, 255, 1'b0);
      do_sample(300, 3, 255, 1'b0);
      do_sample(400, 3, 255, 1'b0);

      do_sample(-1234, 2, 200, 1'b1);

      do_sample(32767, 0, 0, 1'b0);
      do_sample(32000, 1, 255, 1'b0);
      do_sample(-32768, 0, 0, 1'b0);
      do_sample(-32000, 1, 255, 1'b0);

      for (int i = 0; i < 30; i++) begin
         do_sample(int'($signed(16'($urandom))), int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, 255)), 1'b0);
      end

      // Reset while the read data is being captured.
      sample_in = 16'd777;
      delay = AL'(2);
      gain = 8'd100;
      sample_in_valid = 1'b1;
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      check("abort_ctl", {busy, mem_wren, sample_out_valid, overrun}, 0);
      check("abort_addr", mem_addr, 0);
      reset_clear(0);

      for (int k = 0; k < 20; k++) do_sample(k * 100 + 7, 0, 255, 1'b0);

      reset_clear(0);
      do_sample(1000, 1, 128, 1'b0);
      for (int k = 0; k < 4; k++) do_sample(0, 1, 128, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
